// File: rtl/qpsk_upsampler_if.sv
// Symbol-side handshake and sample-side outputs of the QPSK upsampler.
// The slave modport is the design view; the master modport is the driver/consumer view.
interface qpsk_upsampler_if;
  logic        en;
  logic [1:0]  sym_in;
  logic        sym_valid;
  logic        sym_ready;
  logic [31:0] xout;
  logic [31:0] yout;
  logic        sym_strobe;
  logic        underflow;

  modport slave (
    input  en, sym_in, sym_valid,
    output sym_ready, xout, yout, sym_strobe, underflow
  );

  modport master (
    output en, sym_in, sym_valid,
    input  sym_ready, xout, yout, sym_strobe, underflow
  );
endinterface

// File: rtl/qpsk_upsampler.sv
// QPSK symbol mapper with zero-stuffing upsampler: buffers 2-bit symbols in a small
// FIFO and emits one +/-AMP I/Q sample every UPS enabled cycles, zeros in between.
module qpsk_map_lane #(
  parameter int unsigned AMP = 46341
) (
  input  logic        sym_bit,
  output logic [31:0] sample
);
  localparam logic [31:0] POS = 32'(AMP);
  localparam logic [31:0] NEG = ~POS + 32'd1;

  assign sample = sym_bit ? NEG : POS;
endmodule

module qpsk_upsampler #(
  parameter int unsigned AMP   = 46341,
  parameter int unsigned UPS   = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  qpsk_upsampler_if.slave io
);
  localparam int LANES = 2;
  localparam int PW    = $clog2(UPS);
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);

  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count, count_nxt;
  logic [PW-1:0] phase;
  logic          push, slot, pop;
  logic [LANES-1:0]       head;
  logic [LANES-1:0][31:0] lane_sample;

  // Ready looks only at the registered count, so a full FIFO never takes a
  // word even when a pop is happening on the same edge.
  assign io.sym_ready = (count < CW'(DEPTH));
  assign push = io.sym_valid && io.sym_ready;
  assign slot = io.en && (phase == '0);
  assign pop  = slot && (count != '0);
  assign head = mem[rptr];

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= io.sym_in;
  end

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      phase <= '0;
    end else begin
      count <= count_nxt;
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      if (io.en) phase <= (phase == PW'(UPS - 1)) ? '0 : phase + PW'(1);
    end
  end

  // bit0 drives the I lane, bit1 the Q lane
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    qpsk_map_lane #(.AMP(AMP)) u_lane (
      .sym_bit (head[l]),
      .sample  (lane_sample[l])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      io.xout       <= '0;
      io.yout       <= '0;
      io.sym_strobe <= 1'b0;
      io.underflow  <= 1'b0;
    end else begin
      io.xout       <= '0;
      io.yout       <= '0;
      io.sym_strobe <= 1'b0;
      if (slot) begin
        io.sym_strobe <= 1'b1;
        if (count != '0) begin
          io.xout <= lane_sample[0];
          io.yout <= lane_sample[1];
        end else begin
          io.underflow <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_qpsk_upsampler.sv
// Scoreboard bench for qpsk_upsampler: a cycle model queues expected samples on each
// rising edge, and the falling-edge checker pops and compares them against the outputs.
module tb_qpsk_upsampler;
  localparam int UPS   = 8;
  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        s;
    logic        u;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  qpsk_upsampler_if io();

  qpsk_upsampler #(.AMP(46341), .UPS(UPS), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] amp_of(input logic b);
    return b ? 32'hFFFF4AFB : 32'd46341;
  endfunction

  // reference model state
  logic [1:0] m_q[$];
  int         m_phase = 0;
  logic       m_uf = 1'b0;
  exp_t       exp_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      exp_q.delete();
      m_phase = 0;
      m_uf    = 1'b0;
    end else begin
      exp_t  e;
      logic  rdy;
      rdy = (m_q.size() < DEPTH);
      e.x = 32'd0; e.y = 32'd0; e.s = 1'b0;
      if (io.en && m_phase == 0) begin
        e.s = 1'b1;
        if (m_q.size() > 0) begin
          logic [1:0] h;
          h   = m_q.pop_front();
          e.x = amp_of(h[0]);
          e.y = amp_of(h[1]);
        end else begin
          m_uf = 1'b1;
        end
      end
      if (io.sym_valid && rdy) m_q.push_back(io.sym_in);
      if (io.en) m_phase = (m_phase == UPS - 1) ? 0 : m_phase + 1;
      e.u = m_uf;
      exp_q.push_back(e);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_x", io.xout, 32'd0);
      chk("rst_y", io.yout, 32'd0);
      chk("rst_strobe", {31'd0, io.sym_strobe}, 32'd0);
      chk("rst_uf", {31'd0, io.underflow}, 32'd0);
      chk("rst_ready", {31'd0, io.sym_ready}, 32'd1);
    end else if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("xout", io.xout, e.x);
      chk("yout", io.yout, e.y);
      chk("strobe", {31'd0, io.sym_strobe}, {31'd0, e.s});
      chk("underflow", {31'd0, io.underflow}, {31'd0, e.u});
      chk("ready", {31'd0, io.sym_ready}, {31'd0, m_q.size() < DEPTH});
    end
  end

  task automatic drive(input logic en, input logic v, input logic [1:0] s);
    @(negedge clk);
    io.en        = en;
    io.sym_valid = v;
    io.sym_in    = s;
  endtask

  // async reset asserted mid-cycle, checked before the next edge
  task automatic async_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_x", io.xout, 32'd0);
    chk("arst_y", io.yout, 32'd0);
    chk("arst_strobe", {31'd0, io.sym_strobe}, 32'd0);
    chk("arst_uf", {31'd0, io.underflow}, 32'd0);
    chk("arst_ready", {31'd0, io.sym_ready}, 32'd1);
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [1:0] syms [4];
    syms[0] = 2'b00; syms[1] = 2'b11; syms[2] = 2'b01; syms[3] = 2'b10;
    io.en = 1'b0; io.sym_valid = 1'b0; io.sym_in = 2'b00;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;

    // steady stream: fill with en low, then run 4 symbol periods
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, syms[i]);
    drive(1'b0, 1'b0, 2'b00);
    repeat (4 * UPS) drive(1'b1, 1'b0, 2'b00);

    // full FIFO with a fifth symbol held until the first slot frees a place
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, syms[3 - i]);
    repeat (3) drive(1'b0, 1'b1, 2'b11);
    repeat (2) drive(1'b1, 1'b1, 2'b11);
    drive(1'b1, 1'b0, 2'b00);

    // drain past empty into underflow, then push one symbol mid-period
    repeat (6 * UPS) drive(1'b1, 1'b0, 2'b00);
    drive(1'b1, 1'b1, 2'b01);
    repeat (2 * UPS) drive(1'b1, 1'b0, 2'b00);

    // reset mid-operation: 3 queued at phase 3, then reset and run from empty
    async_reset();
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, syms[i]);
    repeat (3) drive(1'b1, 1'b0, 2'b00);
    async_reset();
    repeat (2 * UPS) drive(1'b1, 1'b0, 2'b00);

    // push/pop at count=2 on a slot edge
    async_reset();
    drive(1'b0, 1'b1, 2'b10);
    drive(1'b0, 1'b1, 2'b01);
    drive(1'b1, 1'b1, 2'b11);
    repeat (4 * UPS) drive(1'b1, 1'b0, 2'b00);

    // random traffic with gapped enable
    for (int i = 0; i < 600; i++)
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)));
    drive(1'b0, 1'b0, 2'b00);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/qpsk_upsampler.md
QPSK_UPSAMPLER -- requirements
Module: qpsk_upsampler

Interface
REQ-001 Parameter AMP, default 46341, positive mapping amplitude (unsigned magnitude, < 2^31).
REQ-002 Parameter UPS, default 8, output samples per symbol (>= 2).
REQ-003 Parameter DEPTH, default 4, symbol FIFO depth (power of 2, >= 2).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 en  input  1  sample-rate enable; the phase counter and outputs advance only when high.
REQ-007 sym_in  input  2  symbol; bit0 = I sign, bit1 = Q sign.
REQ-008 sym_valid  input  1  sym_in valid.
REQ-009 sym_ready  output  1  FIFO can accept a symbol.
REQ-010 xout  output  32  I sample, two's complement, registered; feeds the pulse-shaping stage xin.
REQ-011 yout  output  32  Q sample, two's complement, registered; feeds the pulse-shaping stage yin.
REQ-012 sym_strobe  output  1  registered; high for the cycle in which xout/yout carry a symbol-slot sample.
REQ-013 underflow  output  1  sticky flag: a symbol slot found the FIFO empty.

Function
REQ-014 Handshake: a push occurs on any edge with sym_valid && sym_ready; it is independent of en.
REQ-015 sym_ready SHALL equal (count < DEPTH), combinational from the registered count only.
- When full, sym_ready is low even if a pop occurs in the same cycle.
REQ-016 FIFO SHALL be first-in first-out, with wrapping read/write pointers and a count of 0..DEPTH.
- A simultaneous push and pop leaves count unchanged.
REQ-017 Phase counter SHALL run 0..UPS-1, increment on each edge with en=1, and wrap from UPS-1 to 0; it holds when en=0.
REQ-018 Symbol slot: an edge with en=1 and phase==0 (pre-edge value).
- If count>0: pop the head entry, register the mapped sample onto xout/yout, and set sym_strobe=1.
- If count==0: xout=yout=0, sym_strobe=1, underflow<=1.
REQ-019 Mapping: bit=0 -> +AMP, bit=1 -> -AMP (32-bit two's complement; -46341 = 0xFFFF4AFB).
- I uses bit0; Q uses bit1.
REQ-020 Non-slot edges with en=1 (phase 1..UPS-1): xout=yout=0, sym_strobe=0 (zero-stuffing).
REQ-021 Edges with en=0: xout=yout=0, sym_strobe=0; phase, FIFO contents and count (except pushes) hold.
REQ-022 Latency: a symbol at the FIFO head when phase==0 appears on xout/yout one cycle later, for exactly one cycle, followed by UPS-1 zero samples.
REQ-023 A pop SHALL never occur while count==0; a push SHALL never occur while count==DEPTH.
REQ-024 underflow is cleared only by rst.

Reset
REQ-025 While rst is high, independent of clk:
- xout=0, yout=0, sym_strobe=0, underflow=0
- phase=0
- FIFO pointers and count = 0, so sym_ready=1
REQ-026 Assertion of rst mid-symbol SHALL discard all queued symbols and terminate the current output period.
REQ-027 After rst deasserts, the first edge with en=1 is a symbol slot.

Verification
REQ-028 Reset: assert rst asynchronously mid-cycle -> all outputs 0 and sym_ready=1 immediately, before the next edge.
REQ-029 Steady stream: with en=0, push 00,11,01,10; then hold en=1 -> (xout,yout) in order:
- (46341,46341), then 7 zero samples
- (0xFFFF4AFB,0xFFFF4AFB), then 7 zeros
- (0xFFFF4AFB,46341), then 7 zeros
- (46341,0xFFFF4AFB), then 7 zeros
- sym_strobe high every 8th cycle; underflow stays 0 through the 4th symbol.
REQ-030 Full: with en=0, push 4 symbols -> sym_ready=0 after the 4th accept; a 5th held with sym_valid=1 is accepted on the edge after the first slot pop.
REQ-031 Underflow: en=1 with an empty FIFO -> xout=yout=0, sym_strobe=1 on the slot, underflow=1 thereafter; a later push is emitted at the next slot.
REQ-032 Simultaneous push/pop at count=2 -> count stays 2, with order preserved on the output.
REQ-033 Reset mid-operation: assert rst at phase 3 with 3 symbols queued -> FIFO empty, phase 0; after release the first slot shows underflow=1 unless a symbol was pushed first.
